// File: rtl/frame_buffer_arbiter_if.sv
// Camera write stream, VGA read port, RAM port and status of the frame-buffer arbiter.
// The slave modport is the arbiter; the master modport is its surroundings.
interface frame_buffer_arbiter_if #(
  parameter int ADDR_W  = 17,
  parameter int DATA_W  = 12,
  parameter int LEVEL_W = 4
);
  logic              wr_valid;
  logic              wr_sof;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  logic               ready_display;
  logic               frame_done;
  logic               overflow;
  logic [LEVEL_W-1:0] fifo_level;

  modport slave (
    input  wr_valid, wr_sof, wr_data, rd_req, rd_addr, ram_dout,
    output wr_ready, rd_gnt, rd_valid, rd_data,
    output ram_en, ram_we, ram_addr, ram_din,
    output ready_display, frame_done, overflow, fifo_level
  );

  modport master (
    output wr_valid, wr_sof, wr_data, rd_req, rd_addr, ram_dout,
    input  wr_ready, rd_gnt, rd_valid, rd_data,
    input  ram_en, ram_we, ram_addr, ram_din,
    input  ready_display, frame_done, overflow, fifo_level
  );
endinterface

// File: rtl/frame_buffer_arbiter.sv
// Shares a single-port frame-buffer RAM between a buffered camera write stream and
// VGA reads, with read priority bounded by an anti-starvation write slot.
module frame_buffer_arbiter #(
  parameter int ADDR_W       = 17,
  parameter int DATA_W       = 12,
  parameter int FRAME_PIXELS = 76800,
  parameter int WFIFO_DEPTH  = 8,
  parameter int MAX_RD_RUN   = 3
) (
  input  logic                   sys_clk,
  input  logic                   reset,
  frame_buffer_arbiter_if.slave  bus
);
  localparam int PTR_W   = $clog2(WFIFO_DEPTH);
  localparam int LEVEL_W = PTR_W + 1;
  localparam int RUN_W   = $clog2(MAX_RD_RUN + 1);

  localparam logic [ADDR_W-1:0]  FRAME_END  = ADDR_W'(FRAME_PIXELS);
  localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(FRAME_PIXELS - 1);
  localparam logic [LEVEL_W-1:0] FULL_LEVEL = LEVEL_W'(WFIFO_DEPTH);
  localparam logic [RUN_W-1:0]   RUN_LIMIT  = RUN_W'(MAX_RD_RUN);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_READ,
    SLOT_WRITE
  } slot_e;

  entry_t             fifo_mem [WFIFO_DEPTH];
  logic [PTR_W-1:0]   head_ptr;
  logic [PTR_W-1:0]   tail_ptr;
  logic [LEVEL_W-1:0] level;
  logic [ADDR_W-1:0]  pix_cnt;
  logic [RUN_W-1:0]   run_cnt;
  logic               rd_valid_q;
  logic [DATA_W-1:0]  rd_hold;
  logic               ready_q;
  logic               overflow_q;

  slot_e  slot;
  entry_t head;
  entry_t new_entry;
  logic   fifo_nonempty;
  logic   in_frame;
  logic   push;
  logic   pop;
  logic   frame_hit;

  assign head          = fifo_mem[head_ptr];
  assign fifo_nonempty = (level != '0);
  assign bus.wr_ready  = (level != FULL_LEVEL);

  // Once a frame's worth of addresses is used up, further non-sof pixels are ignored.
  assign in_frame  = bus.wr_sof || (pix_cnt != FRAME_END);
  assign push      = bus.wr_valid && in_frame && bus.wr_ready && !reset;
  assign pop       = (slot == SLOT_WRITE);
  assign frame_hit = pop && (head.addr == LAST_ADDR);

  assign new_entry.addr = bus.wr_sof ? '0 : pix_cnt;
  assign new_entry.data = bus.wr_data;

  always_comb begin
    slot = SLOT_IDLE;
    if (reset)
      slot = SLOT_IDLE;
    else if (fifo_nonempty && (run_cnt == RUN_LIMIT))
      slot = SLOT_WRITE;
    else if (bus.rd_req)
      slot = SLOT_READ;
    else if (fifo_nonempty)
      slot = SLOT_WRITE;
  end

  // NOTE: every output gets a default first so this block can never infer a latch.
  always_comb begin
    bus.ram_en   = 1'b0;
    bus.ram_we   = 1'b0;
    bus.ram_addr = '0;
    bus.ram_din  = '0;
    case (slot)
      SLOT_READ: begin
        bus.ram_en   = 1'b1;
        bus.ram_addr = bus.rd_addr;
      end
      SLOT_WRITE: begin
        bus.ram_en   = 1'b1;
        bus.ram_we   = 1'b1;
        bus.ram_addr = head.addr;
        bus.ram_din  = head.data;
      end
      default: ;
    endcase
  end

  assign bus.rd_gnt        = (slot == SLOT_READ);
  assign bus.rd_valid      = rd_valid_q && !reset;
  assign bus.rd_data       = rd_valid_q ? bus.ram_dout : rd_hold;
  assign bus.frame_done    = frame_hit;
  assign bus.ready_display = ready_q;
  assign bus.overflow      = overflow_q;
  assign bus.fifo_level    = level;

  // NOTE: FIFO storage has no reset; the pointers and level alone say which entries are live.
  always_ff @(posedge sys_clk) begin
    if (push)
      fifo_mem[tail_ptr] <= new_entry;
  end

  // NOTE: all state here uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      head_ptr   <= '0;
      tail_ptr   <= '0;
      level      <= '0;
      pix_cnt    <= '0;
      run_cnt    <= '0;
      rd_valid_q <= 1'b0;
      rd_hold    <= '0;
      ready_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (push)
        tail_ptr <= tail_ptr + 1'b1;
      if (pop)
        head_ptr <= head_ptr + 1'b1;
      level <= level + LEVEL_W'(push) - LEVEL_W'(pop);

      // Dropped pixels still consume an address so later pixels stay aligned.
      if (bus.wr_valid && in_frame) begin
        pix_cnt <= bus.wr_sof ? ADDR_W'(1) : pix_cnt + 1'b1;
        if (!bus.wr_ready)
          overflow_q <= 1'b1;
      end

      if ((slot == SLOT_READ) && fifo_nonempty)
        run_cnt <= run_cnt + 1'b1;
      else
        run_cnt <= '0;

      rd_valid_q <= (slot == SLOT_READ);
      if (rd_valid_q)
        rd_hold <= bus.ram_dout;
      if (frame_hit)
        ready_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Directed bench for frame_buffer_arbiter: read path, write drain, read/write
// interleave, frame completion, FIFO overflow and reset with traffic pending.
module tb_frame_buffer_arbiter;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 12;
  localparam int FRAME  = 76800;

  logic sys_clk = 1'b0;
  logic reset   = 1'b1;

  frame_buffer_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEVEL_W(4)) bus ();

  frame_buffer_arbiter dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  // Behavioural single-port RAM with one cycle read latency.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge sys_clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
      else            bus.ram_dout      <= mem[bus.ram_addr];
    end
  end

  logic [ADDR_W-1:0] wlog_addr [$];
  logic [DATA_W-1:0] wlog_data [$];
  int                fd_count = 0;
  logic [ADDR_W-1:0] fd_addr  = '0;
  always @(posedge sys_clk) begin
    if (bus.ram_en && bus.ram_we) begin
      wlog_addr.push_back(bus.ram_addr);
      wlog_data.push_back(bus.ram_din);
    end
    if (bus.frame_done) begin
      fd_count++;
      fd_addr = bus.ram_addr;
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // NOTE: inputs change on the falling edge with blocking assignments, so the DUT sees them settled.
  task automatic step(input logic rst, input logic v, input logic s, input logic [DATA_W-1:0] d,
                      input logic rq, input logic [ADDR_W-1:0] a);
    @(negedge sys_clk);
    reset        = rst;
    bus.wr_valid = v;
    bus.wr_sof   = s;
    bus.wr_data  = d;
    bus.rd_req   = rq;
    bus.rd_addr  = a;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time=%0t limit=%0t", $time, 2_000_000);
    $fatal(1, "watchdog expired");
  end

  logic [DATA_W-1:0] pre  [3] = '{12'hA5A, 12'h123, 12'hFED};
  logic [DATA_W-1:0] px2  [3] = '{12'hF00, 12'h0F0, 12'h00F};
  logic              gnt3 [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 0, 1};
  logic              gnt4 [14] = '{1, 1, 1, 1, 0, 1, 1, 1, 0, 1, 1, 1, 0, 1};
  logic [ADDR_W-1:0] burst_addr [11] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 13};

  initial begin
    int n_before;
    logic [31:0] last;
    logic [31:0] probe;

    bus.wr_valid = 1'b0;
    bus.wr_sof   = 1'b0;
    bus.wr_data  = '0;
    bus.rd_req   = 1'b0;
    bus.rd_addr  = '0;
    for (int i = 0; i < 3; i++) mem[i] = pre[i];

    // Reset: a read request must not be granted while reset is high.
    step(1'b1, 1'b0, 1'b0, '0, 1'b1, '0);
    check("reset_gnt", bus.rd_gnt, 0);
    check("reset_ram_en", bus.ram_en, 0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b1, '0);
    idle();
    check("rst_level", bus.fifo_level, 0);
    check("rst_wr_ready", bus.wr_ready, 1);
    check("rst_overflow", bus.overflow, 0);
    check("rst_ready_display", bus.ready_display, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_frame_done", bus.frame_done, 0);
    check("rst_ram_en", bus.ram_en, 0);

    // Reads only, FIFO empty: granted every cycle, data one cycle later.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, '0, 1'b1, ADDR_W'(i));
      check($sformatf("rd_gnt[%0d]", i), bus.rd_gnt, 1);
      check($sformatf("rd_we[%0d]", i), bus.ram_we, 0);
      check($sformatf("rd_addr[%0d]", i), bus.ram_addr, i);
      check($sformatf("rd_valid[%0d]", i), bus.rd_valid, (i > 0));
      if (i > 0) check($sformatf("rd_data[%0d]", i - 1), bus.rd_data, pre[i-1]);
    end
    idle();
    check("rd_valid_last", bus.rd_valid, 1);
    check("rd_data_last", bus.rd_data, pre[2]);
    check("rd_gnt_off", bus.rd_gnt, 0);
    idle();
    check("rd_valid_drop", bus.rd_valid, 0);
    check("rd_data_held", bus.rd_data, pre[2]);

    // sof + 3 pixels, no reads: written at 0,1,2 on consecutive cycles.
    step(1'b0, 1'b1, 1'b1, px2[0], 1'b0, '0);
    check("w3_first_idle", bus.ram_en, 0);
    for (int k = 0; k < 3; k++) begin
      if (k < 2) step(1'b0, 1'b1, 1'b0, px2[k+1], 1'b0, '0);
      else       idle();
      check($sformatf("w3_we[%0d]", k), bus.ram_we, 1);
      check($sformatf("w3_addr[%0d]", k), bus.ram_addr, k);
      check($sformatf("w3_din[%0d]", k), bus.ram_din, px2[k]);
      check($sformatf("w3_level[%0d]", k), bus.fifo_level, 1);
    end
    idle();
    check("w3_level_end", bus.fifo_level, 0);

    // Reads held with 2 pixels queued (addresses continue at 3): R,R,R,W,R,R,R,W.
    for (int c = 0; c < 10; c++) begin
      step(1'b0, (c < 2), 1'b0, (c == 0) ? 12'h3C3 : 12'hABC, 1'b1, 17'd7);
      check($sformatf("rw_gnt[%0d]", c), bus.rd_gnt, gnt3[c]);
      if (c == 4) begin
        check("rw_w0_addr", bus.ram_addr, 3);
        check("rw_w0_din", bus.ram_din, 12'h3C3);
      end
      if (c == 8) begin
        check("rw_w1_addr", bus.ram_addr, 4);
        check("rw_w1_din", bus.ram_din, 12'hABC);
      end
    end
    idle();
    check("rw_level_end", bus.fifo_level, 0);

    // Full frame then 5 extra pixels: one frame_done, extras silently discarded.
    wlog_addr.delete();
    wlog_data.delete();
    for (int i = 0; i < FRAME; i++) begin
      step(1'b0, 1'b1, (i == 0), DATA_W'(i), 1'b0, '0);
      if (i == 1) check("frame_first_addr", bus.ram_addr, 0);
      if (i == FRAME - 1) begin
        check("frame_ready_before", bus.ready_display, 0);
        check("frame_done_before", bus.frame_done, 0);
      end
    end
    last = FRAME - 1;
    for (int j = 0; j < 5; j++) begin
      step(1'b0, 1'b1, 1'b0, 12'hFFF, 1'b0, '0);
      if (j == 0) begin
        check("frame_done_pulse", bus.frame_done, 1);
        check("frame_last_addr", bus.ram_addr, last);
        check("frame_last_din", bus.ram_din, {20'd0, last[11:0]});
      end
      if (j == 1) begin
        check("frame_done_clear", bus.frame_done, 0);
        check("frame_ready_after", bus.ready_display, 1);
        check("extra_no_write", bus.ram_en, 0);
      end
      check($sformatf("extra_overflow[%0d]", j), bus.overflow, 0);
    end
    idle();
    check("extra_level", bus.fifo_level, 0);
    check("frame_done_count", fd_count, 1);
    check("frame_done_addr", fd_addr, last);
    check("frame_write_count", wlog_addr.size(), FRAME);
    probe = 32'd1000;
    check("frame_mem_1000", mem[probe[ADDR_W-1:0]], probe[11:0]);

    // 14-pixel burst with reads held: pixels 10,11,12 dropped (12 meets a full FIFO
    // even though that cycle pops), pixel 13 lands at address 13.
    wlog_addr.delete();
    wlog_data.delete();
    for (int k = 0; k < 14; k++) begin
      step(1'b0, 1'b1, (k == 0), 12'h100 + DATA_W'(k), 1'b1, 17'd9);
      check($sformatf("burst_gnt[%0d]", k), bus.rd_gnt, gnt4[k]);
      if (k == 10) check("burst_full", bus.wr_ready, 0);
      if (k == 11) check("burst_overflow", bus.overflow, 1);
      if (k == 12) check("burst_full_pop", bus.fifo_level, 8);
    end
    repeat (9) idle();
    check("burst_overflow_sticky", bus.overflow, 1);
    check("burst_level_end", bus.fifo_level, 0);
    check("burst_write_count", wlog_addr.size(), 11);
    for (int e = 0; e < 11 && e < wlog_addr.size(); e++) begin
      check($sformatf("burst_addr[%0d]", e), wlog_addr[e], burst_addr[e]);
      check($sformatf("burst_data[%0d]", e), wlog_data[e], 12'h100 + DATA_W'(burst_addr[e]));
    end

    // Reset with 4 pixels queued and a read in flight.
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 1'b0, 12'h200 + DATA_W'(k), 1'b1, 17'd5);
      check($sformatf("pre_rst_gnt[%0d]", k), bus.rd_gnt, 1);
    end
    n_before = wlog_addr.size();
    step(1'b1, 1'b1, 1'b0, 12'h2FF, 1'b1, 17'd5);
    check("rst_q_level", bus.fifo_level, 4);
    check("rst_q_we", bus.ram_we, 0);
    check("rst_q_en", bus.ram_en, 0);
    check("rst_q_gnt", bus.rd_gnt, 0);
    check("rst_q_rd_valid", bus.rd_valid, 0);
    idle();
    check("post_rst_level", bus.fifo_level, 0);
    check("post_rst_wr_ready", bus.wr_ready, 1);
    check("post_rst_ready_display", bus.ready_display, 0);
    check("post_rst_overflow", bus.overflow, 0);
    check("post_rst_rd_valid", bus.rd_valid, 0);
    check("post_rst_ram_en", bus.ram_en, 0);
    check("post_rst_no_write", wlog_addr.size(), n_before);

    // Address counter restarts at 0 after reset, even without sof.
    step(1'b0, 1'b1, 1'b0, 12'h777, 1'b0, '0);
    check("post_rst_idle", bus.ram_en, 0);
    idle();
    check("post_rst_we", bus.ram_we, 1);
    check("post_rst_addr", bus.ram_addr, 0);
    check("post_rst_din", bus.ram_din, 12'h777);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
